// File: rtl/button_event_sequencer.sv
// button_event_sequencer
//   Avalon-MM master for a 4-bit buttons PIO with edge capture and IRQ.
//   After reset it programs the PIO irq_mask. On each irq it reads and
//   clears edge_capture, then presents the captured key bits to the game
//   logic over a valid/ready handshake.
//   Optional feature macro: BUTTON_SEQ_AUTO_REPEAT_EN adds a held-key timer.
//   When the timer expires, the block polls the PIO data register and emits
//   auto-repeat events (evt_repeat=1). Without the macro, evt_repeat is tied to 0.
module button_event_sequencer #(
  parameter logic [3:0] IRQ_MASK      = 4'hF,
  parameter int         REPEAT_DELAY  = 25000000,
  parameter int         REPEAT_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        pio_irq,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_keys,
  output logic        evt_repeat,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_EDGE,
    S_CAP,
    S_CLR,
    S_OUT,
    S_RD_LVL,
    S_CAP_LVL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  key_q;
  logic [3:0]  lvl_held;
  logic        timer_exp;

  // Bus command for the coming cycle, registered into the avm_* outputs
  logic        cs_nxt;
  logic        wr_n_nxt;
  logic [1:0]  addr_nxt;
  logic [31:0] wdata_nxt;

  // Only the low four data bits carry buttons
  logic unused_rd;
  assign unused_rd = ^avm_readdata[31:4];

  assign lvl_held = avm_readdata[3:0] & IRQ_MASK;
  assign evt_keys = key_q;
  assign busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  // Next-state logic; a pending irq wins over a simultaneous timer expiry
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:    state_nxt = S_IDLE;
      S_IDLE: begin
        if (pio_irq)        state_nxt = S_RD_EDGE;
        else if (timer_exp) state_nxt = S_RD_LVL;
      end
      S_RD_EDGE: state_nxt = S_CAP;
      S_CAP:     state_nxt = S_CLR;
      // A zero capture is spurious: the clear is still issued but no event follows
      S_CLR:     state_nxt = (key_q == 4'd0) ? S_IDLE : S_OUT;
      S_OUT:     if (evt_ready) state_nxt = S_IDLE;
      S_RD_LVL:  state_nxt = S_CAP_LVL;
      S_CAP_LVL: state_nxt = (lvl_held == 4'd0) ? S_IDLE : S_OUT;
      default:   state_nxt = S_INIT;
    endcase
  end

  // Output decode: bus command that matches the state being entered, so that
  // registered readdata lines up with CAP/CAP_LVL. The mask write is issued on
  // the way out of INIT, because reset holds the bus idle while in INIT.
  always_comb begin
    cs_nxt    = 1'b0;
    wr_n_nxt  = 1'b1;
    addr_nxt  = avm_address;
    wdata_nxt = avm_writedata;
    if (state == S_INIT) begin
      cs_nxt    = 1'b1;
      wr_n_nxt  = 1'b0;
      addr_nxt  = 2'd2;
      wdata_nxt = {28'b0, IRQ_MASK};
    end else begin
      unique case (state_nxt)
        S_RD_EDGE: begin
          cs_nxt   = 1'b1;
          addr_nxt = 2'd3;
        end
        S_CAP:     addr_nxt = 2'd3;
        S_CLR: begin
          cs_nxt    = 1'b1;
          wr_n_nxt  = 1'b0;
          addr_nxt  = 2'd3;
          wdata_nxt = 32'd0;
        end
        S_RD_LVL: begin
          cs_nxt   = 1'b1;
          addr_nxt = 2'd0;
        end
        default: ;
      endcase
    end
  end

  // Registered Avalon outputs and event valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 2'd0;
      avm_writedata  <= 32'd0;
      evt_valid      <= 1'b0;
    end else begin
      avm_chipselect <= cs_nxt;
      avm_write_n    <= wr_n_nxt;
      avm_address    <= addr_nxt;
      avm_writedata  <= wdata_nxt;
      evt_valid      <= (state_nxt == S_OUT);
    end
  end

  // Key register: edge capture in CAP, masked level sample in CAP_LVL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                key_q <= 4'd0;
    else if (state == S_CAP)     key_q <= avm_readdata[3:0];
    else if (state == S_CAP_LVL) key_q <= lvl_held;
  end

`ifdef BUTTON_SEQ_AUTO_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  logic [TW-1:0] tmr_cnt;
  logic          tmr_run;
  logic          rpt_q;

  assign timer_exp  = tmr_run && (tmr_cnt == '0);
  assign evt_repeat = rpt_q;

  // Held-key timer: edge events arm it with the initial delay, level polls
  // re-arm it with the repeat period or stop it once all keys are released.
  // It keeps running during OUT; an expiry waits at zero until serviced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_run <= 1'b0;
      tmr_cnt <= '0;
    end else if (state == S_CLR && key_q != 4'd0) begin
      tmr_run <= 1'b1;
      tmr_cnt <= TW'(REPEAT_DELAY);
    end else if (state == S_CAP_LVL) begin
      if (lvl_held != 4'd0) tmr_cnt <= TW'(REPEAT_PERIOD);
      else                  tmr_run <= 1'b0;
    end else if (tmr_run && tmr_cnt != '0) begin
      tmr_cnt <= tmr_cnt - TW'(1);
    end
  end

  // Repeat flag accompanies evt_valid for events that came from a level poll
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                rpt_q <= 1'b0;
    else if (state == S_CAP_LVL) rpt_q <= (state_nxt == S_OUT);
    else if (state != S_OUT)     rpt_q <= 1'b0;
  end
`else
  logic unused_cfg;
  assign unused_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign timer_exp  = 1'b0;
  assign evt_repeat = 1'b0;
`endif

endmodule
